// File: rtl/dict_ring_mlane.sv
// Multi-lane write dictionary: one shared ring of ENTRIES words, newest-first view.
// Asserted lanes are compacted into consecutive slots each cycle; oldest words are overwritten on wrap.
module dict_ring_mlane #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int ENTRIES    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic [LANES-1:0]              i_wr,
  input  logic [LANES*DATA_WIDTH-1:0]   i_w_data,
  output logic [ENTRIES*DATA_WIDTH-1:0] o_data,
  output logic [ENTRIES-1:0]            o_valid,
  output logic [$clog2(ENTRIES):0]      o_count,
  output logic                          o_full,
  output logic [$clog2(ENTRIES)-1:0]    o_wr_ptr
);

  localparam int AW = $clog2(ENTRIES);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   ENT_WIDE = (CW+1)'(ENTRIES);
  localparam logic [CW-1:0] ENT_CNT  = CW'(ENTRIES);

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [DATA_WIDTH-1:0] mem_d [ENTRIES];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [CW-1:0]         pop;
  logic [CW:0]           sum;
  logic [AW-1:0]         wr_slot;
  logic [AW-1:0]         rd_slot;

  // Each asserted lane lands at the pointer plus the number of lower lanes also asserted.
  always_comb begin
    mem_d    = mem_q;
    pop      = '0;
    wr_slot  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_wr[k]) begin
        wr_slot        = wr_ptr_q + pop[AW-1:0];
        mem_d[wr_slot] = i_w_data[k*DATA_WIDTH +: DATA_WIDTH];
        pop            = pop + CW'(1);
      end
    end

    sum      = {1'b0, count_q} + {1'b0, pop};
    count_d  = (sum > ENT_WIDE) ? ENT_CNT : sum[CW-1:0];
    wr_ptr_d = wr_ptr_q + pop[AW-1:0];

    if (i_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_d[i] = '0;
      end
      count_d  = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Logical word j sits one slot behind the pointer per step of age; unwritten words read as zero.
  always_comb begin
    o_data  = '0;
    o_valid = '0;
    rd_slot = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      rd_slot    = wr_ptr_q - AW'(j + 1);
      o_valid[j] = (CW'(j) < count_q);
      if (o_valid[j]) begin
        o_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_slot];
      end
    end
  end

  assign o_count  = count_q;
  assign o_full   = (count_q == ENT_CNT);
  assign o_wr_ptr = wr_ptr_q;

endmodule

// File: tb/tb_dict_ring_mlane.sv
// Scoreboard bench for dict_ring_mlane: history-queue reference model, directed and random traffic.
module tb_dict_ring_mlane;

  localparam int DW = 32;
  localparam int L  = 2;
  localparam int E  = 16;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [L-1:0]    wr;
  logic [L*DW-1:0] wdata;
  logic [E*DW-1:0] o_data;
  logic [E-1:0]    o_valid;
  logic [4:0]      o_count;
  logic            o_full;
  logic [3:0]      o_wr_ptr;

  dict_ring_mlane #(.DATA_WIDTH(DW), .LANES(L), .ENTRIES(E)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_flush  (flush),
    .i_wr     (wr),
    .i_w_data (wdata),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_count  (o_count),
    .o_full   (o_full),
    .o_wr_ptr (o_wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [E*DW-1:0] data;
    logic [E-1:0]    valid;
    logic [4:0]      count;
    logic            full;
    logic [3:0]      ptr;
    int              due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference: newest-first list of words plus total words ever written since the last clear.
  logic [DW-1:0] hist[$];
  int unsigned   total = 0;

  task automatic chk(input string name, input logic [E*DW-1:0] act, input logic [E*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int j);
    return o_data[j*DW +: DW];
  endfunction

  function automatic exp_t model_view(input int due);
    exp_t e;
    e.data  = '0;
    e.valid = '0;
    for (int j = 0; j < hist.size(); j++) begin
      e.data[j*DW +: DW] = hist[j];
      e.valid[j] = 1'b1;
    end
    e.count = 5'(hist.size());
    e.full  = (hist.size() == E);
    e.ptr   = 4'(total % E);
    e.due   = due;
    return e;
  endfunction

  task automatic cycle(input logic r, input logic f, input logic [L-1:0] w, input logic [L*DW-1:0] d);
    rst   = r;
    flush = f;
    wr    = w;
    wdata = d;
    if (r || f) begin
      hist.delete();
      total = 0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (w[k]) begin
          hist.push_front(d[k*DW +: DW]);
          if (hist.size() > E) void'(hist.pop_back());
          total++;
        end
      end
    end
    sb.push_back(model_view(cyc + 1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs for the edge that just happened are compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("sb_data",  o_data,            e.data);
        chk("sb_valid", {496'd0, o_valid}, {496'd0, e.valid});
        chk("sb_count", {507'd0, o_count}, {507'd0, e.count});
        chk("sb_full",  {511'd0, o_full},  {511'd0, e.full});
        chk("sb_ptr",   {508'd0, o_wr_ptr},{508'd0, e.ptr});
      end
    end
  end

  initial begin
    logic [L-1:0]    rw;
    logic [L*DW-1:0] rd;
    int              r;
    rst = 1'b1; flush = 1'b0; wr = '0; wdata = '0;

    cycle(1, 0, 2'b00, '0);
    cycle(1, 0, 2'b11, {32'hDEAD0001, 32'hDEAD0002});
    chk("reset_count", {507'd0, o_count},  '0);
    chk("reset_data",  o_data,             '0);
    chk("reset_ptr",   {508'd0, o_wr_ptr}, '0);

    // Single-lane fill
    for (int i = 1; i <= 3; i++) cycle(0, 0, 2'b01, {32'd0, 32'(i)});
    chk("fill_count", {507'd0, o_count},   512'd3);
    chk("fill_w0",    {480'd0, word(0)},   512'd3);
    chk("fill_w1",    {480'd0, word(1)},   512'd2);
    chk("fill_w2",    {480'd0, word(2)},   512'd1);
    chk("fill_valid", {496'd0, o_valid},   512'h7);
    chk("fill_ptr",   {508'd0, o_wr_ptr},  512'd3);

    // Dual-lane compaction from empty
    cycle(0, 1, 2'b00, '0);
    cycle(0, 0, 2'b11, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
    cycle(0, 0, 2'b10, {32'hCCCC_CCCC, 32'h1111_1111});
    chk("cmp_w0",    {480'd0, word(0)},  {480'd0, 32'hCCCC_CCCC});
    chk("cmp_w1",    {480'd0, word(1)},  {480'd0, 32'hBBBB_BBBB});
    chk("cmp_w2",    {480'd0, word(2)},  {480'd0, 32'hAAAA_AAAA});
    chk("cmp_count", {507'd0, o_count},  512'd3);
    chk("cmp_ptr",   {508'd0, o_wr_ptr}, 512'd3);

    // Wrap and saturation
    cycle(0, 1, 2'b00, '0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 2'b11, {32'(2*i+2), 32'(2*i+1)});
    chk("wrap_count", {507'd0, o_count},  512'd16);
    chk("wrap_full",  {511'd0, o_full},   512'd1);
    chk("wrap_ptr",   {508'd0, o_wr_ptr}, 512'd2);
    chk("wrap_w0",    {480'd0, word(0)},  512'd18);
    chk("wrap_w15",   {480'd0, word(15)}, 512'd3);

    // Flush beats simultaneous writes
    cycle(0, 1, 2'b11, {32'h5555_5555, 32'h6666_6666});
    chk("flush_count", {507'd0, o_count},  '0);
    chk("flush_valid", {496'd0, o_valid},  '0);
    chk("flush_data",  o_data,             '0);
    chk("flush_ptr",   {508'd0, o_wr_ptr}, '0);

    // Reset mid-stream discards that cycle's writes
    cycle(0, 0, 2'b11, {32'd12, 32'd11});
    cycle(0, 0, 2'b11, {32'd14, 32'd13});
    cycle(0, 0, 2'b01, {32'd0,  32'd15});
    chk("pre_rst_count", {507'd0, o_count}, 512'd5);
    cycle(1, 0, 2'b11, {32'd77, 32'd66});
    cycle(0, 0, 2'b01, {32'd0, 32'h0000_ABCD});
    chk("rst_count", {507'd0, o_count},  512'd1);
    chk("rst_w0",    {480'd0, word(0)},  {480'd0, 32'h0000_ABCD});
    chk("rst_ptr",   {508'd0, o_wr_ptr}, 512'd1);

    // Idle hold
    for (int i = 0; i < 10; i++) cycle(0, 0, 2'b00, {$urandom, $urandom});
    chk("idle_count", {507'd0, o_count},  512'd1);
    chk("idle_w0",    {480'd0, word(0)},  {480'd0, 32'h0000_ABCD});
    chk("idle_ptr",   {508'd0, o_wr_ptr}, 512'd1);

    // Random traffic with occasional flush/reset
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      rw = 2'($urandom_range(0, 3));
      rd = {$urandom, $urandom};
      cycle(r < 2, (r >= 2) && (r < 6), rw, rd);
    end
    cycle(0, 0, 2'b00, '0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dict_ring_mlane.md
DICT_RING_MLANE -- requirements
Module: dict_ring_mlane

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of one dictionary word.
REQ-002 The block SHALL have parameter LANES, default 2, the number of write lanes; legal range 1..8.
REQ-003 The block SHALL have parameter ENTRIES, default 16, the dictionary depth; it must be a power of two and at least LANES.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_flush, input, 1 bit: synchronous clear of dictionary contents and occupancy.
REQ-007 The block SHALL have port i_wr, input, LANES bits: per-lane write strobe.
REQ-008 The block SHALL have port i_w_data, input, LANES*DATA_WIDTH bits: lane k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port o_data, output, ENTRIES*DATA_WIDTH bits: the dictionary in logical order; word j in bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port o_valid, output, ENTRIES bits: bit j set when logical word j holds written data.
REQ-011 The block SHALL have port o_count, output, $clog2(ENTRIES)+1 bits: number of valid entries, 0..ENTRIES.
REQ-012 The block SHALL have port o_full, output, 1 bit: high when o_count == ENTRIES.
REQ-013 The block SHALL have port o_wr_ptr, output, $clog2(ENTRIES) bits: the physical slot the next accepted word lands in.

Function
REQ-014 Storage SHALL be a single ring of ENTRIES words shared by all lanes; lanes are not bound to fixed slots.
REQ-015 In each cycle, the asserted lanes SHALL be compacted and written to consecutive slots starting at o_wr_ptr, in ascending lane order; deasserted lanes consume no slot.
REQ-016 The write pointer SHALL advance by popcount(i_wr) modulo ENTRIES; with no strobes asserted, it SHALL hold.
REQ-017 On wrap-around, writes SHALL overwrite the oldest entries; writes are never refused and there is no backpressure.
REQ-018 o_count SHALL increase by popcount(i_wr) and saturate at ENTRIES.
REQ-019 Logical word 0 SHALL be the newest entry (the highest asserted lane of the latest write cycle); word j is the j-th older entry.
REQ-020 Logical word j SHALL map to physical slot (o_wr_ptr - 1 - j) mod ENTRIES.
REQ-021 o_valid[j] SHALL equal (j < o_count); o_data words with o_valid[j] = 0 SHALL read as zero.
REQ-022 Storage, pointer and count SHALL be registered; o_data, o_valid, o_count, o_full and o_wr_ptr are derived from registers only, so a write is visible the cycle after its edge (latency 1).
REQ-023 When i_flush is asserted, the next edge SHALL set the pointer and count to 0 and zero all slots.
REQ-024 When i_flush and i_wr are asserted in the same cycle, the flush SHALL win and the writes SHALL be discarded.
REQ-025 There SHALL be no combinational path from any input to any output.

Reset
REQ-026 While i_reset is high at a rising edge, the block SHALL clear all slots to 0, o_wr_ptr to 0, o_count to 0, o_valid to all 0, o_full to 0 and o_data to all 0.
REQ-027 i_reset SHALL take priority over i_flush and i_wr.
REQ-028 When reset is asserted mid-operation, it SHALL discard that cycle's writes; the first write after release SHALL land in slot 0.

Verification (LANES=2, ENTRIES=16, DATA_WIDTH=32)
REQ-029 The bench SHALL check single-lane fill: i_wr=01 with data 1..3 over 3 cycles -> o_count=3, word0=3, word1=2, word2=1, o_valid=0x0007, o_wr_ptr=3.
REQ-030 The bench SHALL check dual-lane compaction: from empty, apply i_wr=11 with lane0=A, lane1=B, then i_wr=10 with lane1=C -> word0=C, word1=B, word2=A, o_count=3, o_wr_ptr=3.
REQ-031 The bench SHALL check wrap and saturation: 9 cycles of i_wr=11 with data 1..18 -> o_count=16, o_full=1, o_wr_ptr=2, word0=18, word15=3.
REQ-032 The bench SHALL check flush with a write: in a full state, assert i_flush with i_wr=11 -> next cycle o_count=0, o_valid=0, o_data=0, o_wr_ptr=0.
REQ-033 The bench SHALL check reset mid-stream: at o_count=5, assert i_reset for 1 cycle with i_wr=11, then write X on lane0 -> o_count=1, word0=X, o_wr_ptr=1.
REQ-034 The bench SHALL check idle hold: after any state, 10 cycles with i_wr=00 and i_flush=0 -> all outputs unchanged.
